// File: rtl/id_imm_ctrl.sv
// Decode-stage controller for the RV32 immediate generator: classifies instructions, drives the
// generator select, and buffers {instr, pc, imm, sel} in order toward execute. Option: ID_ILLEGAL_DET_EN.
module id_imm_ctrl #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic [24:0]     imm_src,
  output logic [2:0]      imm_sel,
  input  logic [31:0]     imm_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_has_imm,
  output logic            out_illegal
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcMisc   = 7'b0001111;

  localparam logic [2:0] SelNone = 3'b111;

  logic [31:0]     instr_q [BUF_DEPTH];
  logic [PC_W-1:0] pc_q    [BUF_DEPTH];
  logic [31:0]     imm_q   [BUF_DEPTH];
  logic [2:0]      sel_q   [BUF_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;
  logic [31:0]     wr_imm;

  assign imm_src = in_instr[31:7];

  always_comb begin
    imm_sel = SelNone;
    case (in_instr[6:0])
      OpcOpImm: imm_sel = (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) ? 3'b101 : 3'b000;
      OpcLoad, OpcJalr, OpcSystem: imm_sel = 3'b000;
      OpcStore:                    imm_sel = 3'b001;
      OpcBranch:                   imm_sel = 3'b010;
      OpcLui, OpcAuipc:            imm_sel = 3'b011;
      OpcJal:                      imm_sel = 3'b100;
      default:                     imm_sel = SelNone;
    endcase
  end

  assign in_ready  = (cnt_q != CntW'(BUF_DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  // The generator output is garbage for the no-immediate select; store a clean zero.
  assign wr_imm    = (imm_sel == SelNone) ? 32'h0 : imm_val;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Entries reset so the head reads the documented idle values after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        imm_q[i]   <= '0;
        sel_q[i]   <= SelNone;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
      imm_q[wr_ptr_q]   <= wr_imm;
      sel_q[wr_ptr_q]   <= imm_sel;
    end
  end

  assign out_instr   = instr_q[rd_ptr_q];
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_imm     = imm_q[rd_ptr_q];
  assign out_imm_sel = sel_q[rd_ptr_q];
  assign out_has_imm = (sel_q[rd_ptr_q] != SelNone);

`ifdef ID_ILLEGAL_DET_EN
  logic ill_q [BUF_DEPTH];
  logic recognised;

  // Every recognised opcode ends in 2'b11, so this also rejects compressed encodings.
  always_comb begin
    recognised = 1'b0;
    case (in_instr[6:0])
      OpcOpImm, OpcLoad, OpcJalr, OpcSystem, OpcStore, OpcBranch,
      OpcLui, OpcAuipc, OpcJal, OpcOp, OpcMisc: recognised = 1'b1;
      default:                                  recognised = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) ill_q[i] <= 1'b0;
    end else if (push) begin
      ill_q[wr_ptr_q] <= ~recognised;
    end
  end

  assign out_illegal = ill_q[rd_ptr_q];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Bench for id_imm_ctrl: directed vector table, multi-cycle corner sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_id_imm_ctrl;

  localparam int unsigned PC_W = 32;
  localparam int unsigned D    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr, imm_val, out_instr, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [24:0]     imm_src;
  logic [2:0]      imm_sel, out_imm_sel;
  logic            out_has_imm, out_illegal;

  id_imm_ctrl #(.PC_W(PC_W), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .imm_src(imm_src), .imm_sel(imm_sel),
    .imm_val(imm_val), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_imm_sel(out_imm_sel), .out_has_imm(out_has_imm),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic [2:0]      sel;
    logic            ill;
  } ent_t;

  ent_t q[$];
  logic acc;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        legal;
  } vec_t;

  vec_t vecs[14];
  logic [6:0] ops[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate type from the opcode table.
  function automatic logic [2:0] ref_sel(input logic [31:0] ins);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    if (op == 7'b0010011) return (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
    if (op == 7'b0000011 || op == 7'b1100111 || op == 7'b1110011) return 3'b000;
    if (op == 7'b0100011) return 3'b001;
    if (op == 7'b1100011) return 3'b010;
    if (op == 7'b0110111 || op == 7'b0010111) return 3'b011;
    if (op == 7'b1101111) return 3'b100;
    return 3'b111;
  endfunction

  function automatic logic ref_legal(input logic [31:0] ins);
    for (int i = 0; i < 11; i++) if (ins[6:0] == ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [2:0] sel);
    case (sel)
      3'b000: return {{20{ins[31]}}, ins[31:20]};
      3'b001: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011: return {ins[31:12], 12'h0};
      3'b100: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b101: return {27'h0, ins[24:20]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_ill(input logic [31:0] ins);
`ifdef ID_ILLEGAL_DET_EN
    return ~ref_legal(ins);
`else
    return 1'b0 & ref_legal(ins);
`endif
  endfunction

  // Immediate generator stand-in; returns junk when no immediate is selected.
  logic [31:0] gen_ins;
  assign gen_ins = {imm_src, 7'b0};
  always_comb begin
    imm_val = 32'hDEADBEEF;
    if (imm_sel != 3'b111) imm_val = ref_imm(gen_ins, imm_sel);
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Checks outputs mid-cycle against the model, then commits the model at the clock edge.
  task automatic tick();
    ent_t e;
    logic push, pop;
    @(negedge clk);
    chk("in_ready", in_ready, q.size() != D);
    chk("out_valid", out_valid, q.size() != 0);
    chk("imm_sel", imm_sel, ref_sel(in_instr));
    chk("imm_src", imm_src, in_instr[31:7]);
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_imm_sel", out_imm_sel, q[0].sel);
      chk("out_has_imm", out_has_imm, q[0].sel != 3'b111);
      chk("out_illegal", out_illegal, q[0].ill);
    end
    push = in_valid && (q.size() != D) && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    acc  = push;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        e.sel   = ref_sel(in_instr);
        e.imm   = ref_imm(in_instr, e.sel);
        e.ill   = exp_ill(in_instr);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    else if (k == 11) r[6:0] = 7'b0010011;
    return r;
  endfunction

  initial begin
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
    vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b1};  // addi x1,x0,-1
    vecs[1]  = '{32'h4030D093, 3'b101, 32'h00000003, 1'b1};  // srai x1,x1,3
    vecs[2]  = '{32'h002081B3, 3'b111, 32'h00000000, 1'b1};  // add
    vecs[3]  = '{32'h00309093, 3'b101, 32'h00000003, 1'b1};  // slli
    vecs[4]  = '{32'h00112623, 3'b001, 32'h0000000C, 1'b1};  // sw x1,12(x2)
    vecs[5]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b1};  // beq -4
    vecs[6]  = '{32'h12345037, 3'b011, 32'h12345000, 1'b1};  // lui
    vecs[7]  = '{32'h00001017, 3'b011, 32'h00001000, 1'b1};  // auipc
    vecs[8]  = '{32'h0080006F, 3'b100, 32'h00000008, 1'b1};  // jal +8
    vecs[9]  = '{32'hFF812083, 3'b000, 32'hFFFFFFF8, 1'b1};  // lw -8
    vecs[10] = '{32'h00000073, 3'b000, 32'h00000000, 1'b1};  // ecall
    vecs[11] = '{32'h0000000F, 3'b111, 32'h00000000, 1'b1};  // fence
    vecs[12] = '{32'h0000007F, 3'b111, 32'h00000000, 1'b0};  // unknown opcode
    vecs[13] = '{32'h00000000, 3'b111, 32'h00000000, 1'b0};  // low bits 00

    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_imm_sel", out_imm_sel, 3'b111);
    chk("rst_out_has_imm", out_has_imm, 1'b0);
    chk("rst_out_illegal", out_illegal, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: one instruction at a time through an empty buffer.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].instr, PC_W'(32'h1000 + 4 * i), 1'b1, 1'b0);
      #1 chk("tbl_sel", imm_sel, vecs[i].sel);
      tick();
      drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_imm", out_imm, vecs[i].imm);
      chk("tbl_has_imm", out_has_imm, vecs[i].sel != 3'b111);
`ifdef ID_ILLEGAL_DET_EN
      chk("tbl_illegal", out_illegal, ~vecs[i].legal);
`else
      chk("tbl_illegal", out_illegal, 1'b0);
`endif
      tick();
    end

    // Backpressure: A,B fill the buffer, C waits until the first pop frees a slot.
    drive(1'b1, 32'h00100093, 32'hA0, 1'b0, 1'b0); tick();
    chk("bp_acc_a", acc, 1'b1);
    drive(1'b1, 32'h00200113, 32'hB0, 1'b0, 1'b0); tick();
    chk("bp_acc_b", acc, 1'b1);
    drive(1'b1, 32'h00300193, 32'hC0, 1'b0, 1'b0);
    chk("bp_full_ready", in_ready, 1'b0);
    tick();
    chk("bp_acc_c_blocked", acc, 1'b0);
    drive(1'b1, 32'h00300193, 32'hC0, 1'b1, 1'b0);
    chk("bp_head_a", out_pc, 32'hA0);
    tick();
    chk("bp_head_b", out_pc, 32'hB0);
    chk("bp_ready_after_pop", in_ready, 1'b1);
    tick();
    chk("bp_acc_c", acc, 1'b1);
    chk("bp_head_c", out_pc, 32'hC0);
    drive(1'b0, 32'h0, '0, 1'b1, 1'b0); tick();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while full with a same-cycle push, then async reset with one entry held.
    drive(1'b1, 32'h00100093, 32'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00200113, 32'h20, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00300193, 32'h30, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    tick();
    chk("fl_c_not_stored", out_valid, 1'b0);
    drive(1'b1, 32'h00400213, 32'h40, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    chk("rst_mid_pre", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), PC_W'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
